// File: rtl/q_6_47_serializer.sv
// Parallel-to-serial source for the q_6_47 odd-parity detector.
// MSB-first shifter with optional parity bit and inter-frame gap.
module q_6_47_serializer #(
    parameter int WIDTH      = 8,
    parameter int ADD_PARITY = 1,
    parameter int PARITY_ODD = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP =
        (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_GAP
    } state_t;

    // State entered once the last frame bit has been sent.
    localparam state_t POST_ST = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             par_q, par_d;

    logic x_out_q, x_out_d;
    logic bit_valid_q, bit_valid_d;
    logic frame_start_q, frame_start_d;
    logic frame_end_q, frame_end_d;
    logic busy_q, busy_d;
    logic load_ready_q, load_ready_d;

    logic hs;

    assign hs = load_valid & load_ready_q;

    // Next-state: frame sequencing, shifting and bit/gap counting.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        par_d   = par_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                gap_d = '0;
                if (hs) begin
                    state_d = ST_SHIFT;
                    shreg_d = data_in;
                    par_d   = (PARITY_ODD != 0) ? ~^data_in : ^data_in;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = (ADD_PARITY != 0) ? ST_PARITY : POST_ST;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end
            end
            ST_PARITY: begin
                state_d = POST_ST;
            end
            ST_GAP: begin
                if (gap_q == LAST_GAP) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        x_out_d       = 1'b0;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        load_ready_d  = (state_d == ST_IDLE);
        if (state_d == ST_SHIFT) begin
            x_out_d       = shreg_d[WIDTH-1];
            bit_valid_d   = 1'b1;
            frame_start_d = (state_q == ST_IDLE);
            frame_end_d   = (ADD_PARITY == 0) && (cnt_d == LAST_BIT);
        end else if (state_d == ST_PARITY) begin
            x_out_d     = par_d;
            bit_valid_d = 1'b1;
            frame_end_d = 1'b1;
        end
    end

    // Datapath and FSM registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            par_q   <= par_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            x_out_q       <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
            load_ready_q  <= 1'b1;
        end else begin
            x_out_q       <= x_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
            load_ready_q  <= load_ready_d;
        end
    end

    assign x_out       = x_out_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;
    assign load_ready  = load_ready_q;

endmodule

// File: tb/tb_q_6_47_serializer.sv
// Bench for q_6_47_serializer: three parameterizations checked
// against a frame-level reference model.
module tb_q_6_47_serializer;

    logic       clk;
    logic       rstb;
    logic       lv  [3];
    logic [7:0] di  [3];
    logic       rdy [3];
    logic       xo  [3];
    logic       bv  [3];
    logic       fs  [3];
    logic       fe  [3];
    logic       bz  [3];

    int checks = 0;
    int errors = 0;

    // Per-instance settings: parity bit present, gap cycles, odd parity.
    int pa [3] = '{1, 1, 0};
    int ga [3] = '{1, 1, 0};
    int oa [3] = '{1, 0, 1};

    q_6_47_serializer #(.WIDTH(8), .ADD_PARITY(1), .PARITY_ODD(1),
                        .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rstb(rstb), .data_in(di[0]), .load_valid(lv[0]),
        .load_ready(rdy[0]), .x_out(xo[0]), .bit_valid(bv[0]),
        .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));

    q_6_47_serializer #(.WIDTH(8), .ADD_PARITY(1), .PARITY_ODD(0),
                        .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rstb(rstb), .data_in(di[1]), .load_valid(lv[1]),
        .load_ready(rdy[1]), .x_out(xo[1]), .bit_valid(bv[1]),
        .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));

    q_6_47_serializer #(.WIDTH(8), .ADD_PARITY(0), .PARITY_ODD(1),
                        .GAP_CYCLES(0)) dut2 (
        .clk(clk), .rstb(rstb), .data_in(di[2]), .load_valid(lv[2]),
        .load_ready(rdy[2]), .x_out(xo[2]), .bit_valid(bv[2]),
        .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: frame bit i of word w (data MSB-first, then parity).
    function automatic logic exp_bit(input logic [7:0] w, input int i,
                                     input int odd);
        int ones;
        if (i < 8) return w[7-i];
        ones = $countones(w);
        if (odd != 0) return (ones % 2) == 0;
        return (ones % 2) == 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (rdy[s] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (rdy[s] !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready dut%0d: got %b want 1", s, rdy[s]);
        end
    endtask

    // Load one word and check the whole frame, gap and return to idle.
    task automatic send(input int s, input logic [7:0] w);
        int  nb = 8 + pa[s];
        logic e;
        wait_ready(s);
        lv[s] = 1'b1;
        di[s] = w;
        step();
        lv[s] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            e = exp_bit(w, i, oa[s]);
            checks++;
            if (xo[s] !== e || bv[s] !== 1'b1) begin
                errors++;
                $display("FAIL bit dut%0d w=%h i=%0d: got x=%b v=%b want x=%b v=1",
                         s, w, i, xo[s], bv[s], e);
            end
            checks++;
            if (fs[s] !== (i == 0) || fe[s] !== (i == nb - 1)) begin
                errors++;
                $display("FAIL strobe dut%0d w=%h i=%0d: got s=%b e=%b want s=%b e=%b",
                         s, w, i, fs[s], fe[s], i == 0, i == nb - 1);
            end
            checks++;
            if (rdy[s] !== 1'b0 || bz[s] !== 1'b1) begin
                errors++;
                $display("FAIL busy dut%0d i=%0d: got r=%b b=%b want r=0 b=1",
                         s, i, rdy[s], bz[s]);
            end
            lv[s] = 1'($urandom_range(0, 1));
            di[s] = 8'($urandom);
            step();
        end
        lv[s] = 1'b0;
        for (int g = 0; g < ga[s]; g++) begin
            checks++;
            if (bv[s] !== 1'b0 || xo[s] !== 1'b0 || bz[s] !== 1'b1 ||
                rdy[s] !== 1'b0) begin
                errors++;
                $display("FAIL gap dut%0d: got v=%b x=%b b=%b r=%b want 0 0 1 0",
                         s, bv[s], xo[s], bz[s], rdy[s]);
            end
            step();
        end
        checks++;
        if (rdy[s] !== 1'b1 || bz[s] !== 1'b0 || bv[s] !== 1'b0 ||
            fe[s] !== 1'b0) begin
            errors++;
            $display("FAIL idle dut%0d: got r=%b b=%b v=%b e=%b want 1 0 0 0",
                     s, rdy[s], bz[s], bv[s], fe[s]);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        for (int s = 0; s < 3; s++) begin
            lv[s] = 1'b0;
            di[s] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (xo[s] !== 1'b0 || bv[s] !== 1'b0 || bz[s] !== 1'b0 ||
                rdy[s] !== 1'b1 || fs[s] !== 1'b0 || fe[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got x=%b v=%b b=%b r=%b s=%b e=%b",
                         s, xo[s], bv[s], bz[s], rdy[s], fs[s], fe[s]);
            end
        end
        rstb = 1'b1;
        step();
    endtask

    task automatic test_known_words();
        send(0, 8'hA5);
        send(0, 8'h01);
        send(0, 8'h00);
        send(1, 8'h00);
        send(1, 8'h01);
        send(2, 8'hA5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 15; k++) begin
            send(0, 8'($urandom));
            send(1, 8'($urandom));
            send(2, 8'($urandom));
        end
    endtask

    // load_valid held high; frame timing derived from the frame period.
    task automatic test_stream(input int s, input int nfr, input bit rnd,
                               input logic [7:0] fixed);
        int nb = 8 + pa[s];
        int period = 1 + nb + ga[s];
        int ph;
        logic [7:0] word = fixed;
        logic acc = 1'b0;
        logic ev, ex, ep;
        wait_ready(s);
        lv[s] = 1'b1;
        for (int c = 0; c < nfr * period; c++) begin
            ph = c % period;
            ev = (ph >= 1) && (ph <= nb);
            ex = ev ? exp_bit(word, ph - 1, oa[s]) : 1'b0;
            checks++;
            if (rdy[s] !== (ph == 0) || bv[s] !== ev || xo[s] !== ex) begin
                errors++;
                $display("FAIL stream dut%0d c=%0d: got r=%b v=%b x=%b want r=%b v=%b x=%b",
                         s, c, rdy[s], bv[s], xo[s], ph == 0, ev, ex);
            end
            checks++;
            if (fs[s] !== (ph == 1) || fe[s] !== (ph == nb)) begin
                errors++;
                $display("FAIL stream_strobe dut%0d c=%0d: got s=%b e=%b",
                         s, c, fs[s], fe[s]);
            end
            if (bv[s] === 1'b1) acc = acc ^ xo[s];
            if (ph == nb) begin
                ep = (pa[s] != 0) ? (oa[s] != 0)
                                  : 1'($countones(word) % 2);
                checks++;
                if (acc !== ep) begin
                    errors++;
                    $display("FAIL frame_parity dut%0d c=%0d: got %b want %b",
                             s, c, acc, ep);
                end
                acc = 1'b0;
            end
            if (rnd) di[s] = 8'($urandom);
            else     di[s] = fixed;
            if (ph == 0) word = di[s];
            if (c == nfr * period - 1) lv[s] = 1'b0;
            step();
        end
        checks++;
        if (rdy[s] !== 1'b1 || bz[s] !== 1'b0) begin
            errors++;
            $display("FAIL stream_end dut%0d: got r=%b b=%b want 1 0",
                     s, rdy[s], bz[s]);
        end
    endtask

    task automatic test_back_to_back();
        test_stream(0, 3, 1'b1, 8'h00);
    endtask

    task automatic test_no_parity_stream();
        test_stream(2, 4, 1'b0, 8'h3C);
    endtask

    task automatic test_reset_mid_frame();
        wait_ready(0);
        lv[0] = 1'b1;
        di[0] = 8'hFF;
        step();
        lv[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (xo[0] !== 1'b1 || bv[0] !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset bit %0d: got x=%b v=%b want 1 1",
                         i, xo[0], bv[0]);
            end
            if (i < 3) step();
        end
        rstb = 1'b0;
        #1;
        checks++;
        if (xo[0] !== 1'b0 || bv[0] !== 1'b0 || bz[0] !== 1'b0 ||
            rdy[0] !== 1'b1 || fs[0] !== 1'b0 || fe[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: got x=%b v=%b b=%b r=%b s=%b e=%b",
                     xo[0], bv[0], bz[0], rdy[0], fs[0], fe[0]);
        end
        @(posedge clk);
        #1;
        rstb = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (fe[0] !== 1'b0 || bv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset c=%0d: got e=%b v=%b r=%b want 0 0 1",
                         c, fe[0], bv[0], rdy[0]);
            end
            step();
        end
        send(0, 8'h80);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_words();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_parity_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
